// File: rtl/mem_stage_async_if.sv
// EX/MEM/WB/data-SRAM signal bundle for mem_stage_async.
// The slave modport is the stage itself; master is whoever drives it (EX, memory, WB).
interface mem_stage_async_if #(parameter int DATA_W = 32);
  logic              flush;
  logic              ex_cancel_req;
  logic              ex_to_mem_valid;
  logic              mem_allow_in;
  logic [31:0]       ex_pc;
  logic [DATA_W-1:0] ex_result;
  logic              ex_rf_we;
  logic [4:0]        ex_rf_waddr;
  logic              ex_res_from_mem;
  logic              ex_req_issued;
  logic [1:0]        ex_ld_size;
  logic              ex_ld_unsigned;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              mem_to_wb_valid;
  logic              wb_allow_in;
  logic [DATA_W-1:0] mem_result;
  logic              mem_rf_we;
  logic [4:0]        mem_rf_waddr;
  logic [31:0]       mem_pc;
  logic              mem_byp_valid;
  logic [4:0]        mem_byp_waddr;
  logic [DATA_W-1:0] mem_byp_data;
  logic              mem_byp_stall;

  modport slave (
    input  flush, ex_cancel_req, ex_to_mem_valid, ex_pc, ex_result, ex_rf_we,
           ex_rf_waddr, ex_res_from_mem, ex_req_issued, ex_ld_size, ex_ld_unsigned,
           data_sram_data_ok, data_sram_rdata, wb_allow_in,
    output mem_allow_in, mem_to_wb_valid, mem_result, mem_rf_we, mem_rf_waddr,
           mem_pc, mem_byp_valid, mem_byp_waddr, mem_byp_data, mem_byp_stall
  );

  modport master (
    output flush, ex_cancel_req, ex_to_mem_valid, ex_pc, ex_result, ex_rf_we,
           ex_rf_waddr, ex_res_from_mem, ex_req_issued, ex_ld_size, ex_ld_unsigned,
           data_sram_data_ok, data_sram_rdata, wb_allow_in,
    input  mem_allow_in, mem_to_wb_valid, mem_result, mem_rf_we, mem_rf_waddr,
           mem_pc, mem_byp_valid, mem_byp_waddr, mem_byp_data, mem_byp_stall
  );
endinterface

// File: rtl/mem_stage_async.sv
// MEM pipeline stage with a variable-latency data-SRAM response (data_ok),
// response buffering under WB backpressure and discard of post-flush responses.
module mem_stage_async #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  mem_stage_async_if.slave   bus
);
  localparam int OFS_W = $clog2(DATA_W/8);

  logic              valid_r, wait_rsp, buf_valid;
  logic [CNT_W-1:0]  drop_cnt, drop_nxt;
  logic [DATA_W-1:0] rdata_buf;
  logic [31:0]       pc_r;
  logic [DATA_W-1:0] result_r;
  logic              rf_we_r, res_from_mem_r, ld_unsigned_r;
  logic [4:0]        waddr_r;
  logic [1:0]        ld_size_r;

  logic rsp_hit, ready_go, allow_in, latch, drop_inc, drop_dec;

  assign rsp_hit  = bus.data_sram_data_ok & (drop_cnt == '0) & wait_rsp & !buf_valid;
  assign ready_go = !wait_rsp | buf_valid | rsp_hit;
  assign allow_in = !valid_r | (ready_go & bus.wb_allow_in);
  assign latch    = bus.ex_to_mem_valid & allow_in & !bus.flush;

  // A flushed request whose response has not arrived yet leaves a stale response in flight.
  assign drop_inc = bus.flush & valid_r & wait_rsp & !buf_valid & !rsp_hit;
  assign drop_dec = bus.data_sram_data_ok & (drop_cnt != '0);
  assign drop_nxt = drop_cnt + CNT_W'(drop_inc) + CNT_W'(bus.ex_cancel_req) - CNT_W'(drop_dec);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r        <= 1'b0;
      wait_rsp       <= 1'b0;
      buf_valid      <= 1'b0;
      drop_cnt       <= '0;
      rdata_buf      <= '0;
      pc_r           <= '0;
      result_r       <= '0;
      rf_we_r        <= 1'b0;
      waddr_r        <= '0;
      res_from_mem_r <= 1'b0;
      ld_size_r      <= '0;
      ld_unsigned_r  <= 1'b0;
    end else begin
      drop_cnt <= drop_nxt;
      if (bus.flush) begin
        valid_r   <= 1'b0;
        wait_rsp  <= 1'b0;
        buf_valid <= 1'b0;
      end else if (allow_in) begin
        valid_r   <= bus.ex_to_mem_valid;
        wait_rsp  <= latch & bus.ex_req_issued;
        buf_valid <= 1'b0;
      end else if (rsp_hit & !bus.wb_allow_in) begin
        buf_valid <= 1'b1;
        rdata_buf <= bus.data_sram_rdata;
      end
      if (latch) begin
        pc_r           <= bus.ex_pc;
        result_r       <= bus.ex_result;
        rf_we_r        <= bus.ex_rf_we;
        waddr_r        <= bus.ex_rf_waddr;
        res_from_mem_r <= bus.ex_res_from_mem;
        ld_size_r      <= bus.ex_ld_size;
        ld_unsigned_r  <= bus.ex_ld_unsigned;
      end
    end
  end

  // Load extraction from the live response or the buffered copy.
  logic [DATA_W-1:0] raw, ext, w_ext;
  logic [OFS_W-1:0]  off;
  logic [7:0]        b;
  logic [15:0]       h;
  logic              sgn;

  assign raw = buf_valid ? rdata_buf : bus.data_sram_rdata;
  assign off = result_r[OFS_W-1:0];
  assign sgn = !ld_unsigned_r;
  assign b   = raw[{off, 3'b000} +: 8];
  assign h   = raw[{off[OFS_W-1:1], 4'b0000} +: 16];

  generate
    if (DATA_W == 64) begin : g_w64
      logic [31:0] w;
      assign w     = raw[{off[OFS_W-1], 5'b00000} +: 32];
      assign w_ext = {{32{sgn & w[31]}}, w};
    end else begin : g_w32
      assign w_ext = raw;
    end
  endgenerate

  always_comb begin
    ext = raw;
    case (ld_size_r)
      2'd0:    ext = {{(DATA_W-8){sgn & b[7]}}, b};
      2'd1:    ext = {{(DATA_W-16){sgn & h[15]}}, h};
      2'd2:    ext = w_ext;
      default: ext = raw;
    endcase
  end

  assign bus.mem_allow_in    = allow_in;
  assign bus.mem_to_wb_valid = valid_r & ready_go;
  assign bus.mem_result      = res_from_mem_r ? ext : result_r;
  assign bus.mem_rf_we       = rf_we_r;
  assign bus.mem_rf_waddr    = waddr_r;
  assign bus.mem_pc          = pc_r;
  assign bus.mem_byp_valid   = valid_r & rf_we_r;
  assign bus.mem_byp_waddr   = waddr_r;
  assign bus.mem_byp_data    = bus.mem_result;
  assign bus.mem_byp_stall   = valid_r & res_from_mem_r & !ready_go;
endmodule
